// File: rtl/tile_bin_pkg.sv
// Shared state type, default configuration and small helpers for the tile light binner.
// Grid dimensions derive from the screen and tile sizes through ceil_div.
package tile_bin_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WALK  = 2'd2
  } state_e;

  localparam int DEF_SCREEN_W   = 1920;
  localparam int DEF_SCREEN_H   = 1080;
  localparam int DEF_TILE_W     = 16;
  localparam int DEF_TILE_H     = 16;
  localparam int DEF_MAX_LIGHTS = 64;
  localparam int DEF_COORD_W    = 16;

  // Widest mask the popcount helper handles; masks are zero-extended into it.
  localparam int POPCNT_MAX_W = 256;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned tile_index(input int unsigned tx, input int unsigned ty,
                                             input int unsigned ntx);
    return ty * ntx + tx;
  endfunction

  function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCNT_MAX_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tile_bbox_clamp.sv
// Converts an inclusive pixel bounding box to a tile rectangle, clamps the far
// corner to the grid and flags boxes that must be discarded.
module tile_bbox_clamp #(
  parameter int COORD_W    = 16,
  parameter int TILE_W     = 16,
  parameter int TILE_H     = 16,
  parameter int NTX        = 120,
  parameter int NTY        = 68,
  parameter int MAX_LIGHTS = 64,
  parameter int LID_W      = 6,
  parameter int TX_W       = 7,
  parameter int TY_W       = 7
) (
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] x1_i,
  input  logic [COORD_W-1:0] y1_i,
  input  logic [LID_W-1:0]   id_i,
  output logic [TX_W-1:0]    tx0_o,
  output logic [TX_W-1:0]    tx1_o,
  output logic [TY_W-1:0]    ty0_o,
  output logic [TY_W-1:0]    ty1_o,
  output logic               drop_o
);

  localparam int XSH  = $clog2(TILE_W);
  localparam int YSH  = $clog2(TILE_H);
  localparam int IDW1 = LID_W + 1;
  localparam logic [COORD_W-1:0] TX_MAX   = COORD_W'(NTX - 1);
  localparam logic [COORD_W-1:0] TY_MAX   = COORD_W'(NTY - 1);
  localparam logic [IDW1-1:0]    ID_LIMIT = IDW1'(MAX_LIGHTS);

  logic [COORD_W-1:0] tx0Full, tx1Full, ty0Full, ty1Full;

  // The near corner is never clamped: a box starting off-grid is dropped instead.
  always_comb begin
    tx0Full = x0_i >> XSH;
    tx1Full = x1_i >> XSH;
    ty0Full = y0_i >> YSH;
    ty1Full = y1_i >> YSH;
    tx0_o   = TX_W'(tx0Full);
    ty0_o   = TY_W'(ty0Full);
    tx1_o   = TX_W'((tx1Full > TX_MAX) ? TX_MAX : tx1Full);
    ty1_o   = TY_W'((ty1Full > TY_MAX) ? TY_MAX : ty1Full);
    drop_o  = (x0_i > x1_i) || (y0_i > y1_i) || (tx0Full > TX_MAX) ||
              (ty0Full > TY_MAX) || ({1'b0, id_i} >= ID_LIMIT);
  end

endmodule

// File: rtl/tile_light_binner_seq.sv
// Sequential light-to-tile binner: sweeps masks clear, walks each accepted light's
// tile rectangle one tile per cycle, and serves per-tile mask readback with popcount.
module tile_light_binner_seq
  import tile_bin_pkg::*;
#(
  parameter int SCREEN_W   = DEF_SCREEN_W,
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter int TILE_W     = DEF_TILE_W,
  parameter int TILE_H     = DEF_TILE_H,
  parameter int MAX_LIGHTS = DEF_MAX_LIGHTS,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int LID_W      = $clog2(MAX_LIGHTS),
  parameter int NTX        = ceil_div(SCREEN_W, TILE_W),
  parameter int NTY        = ceil_div(SCREEN_H, TILE_H),
  parameter int NT_W       = $clog2(NTX * NTY),
  parameter int CNT_W      = $clog2(MAX_LIGHTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LID_W-1:0]      in_light_id,
  input  logic [COORD_W-1:0]    in_x0,
  input  logic [COORD_W-1:0]    in_y0,
  input  logic [COORD_W-1:0]    in_x1,
  input  logic [COORD_W-1:0]    in_y1,
  input  logic                  clear_req,
  output logic                  clear_done,
  output logic                  busy,
  output logic                  drop,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [NT_W-1:0]       rd_tile,
  output logic                  rd_resp_valid,
  output logic [MAX_LIGHTS-1:0] rd_mask,
  output logic [CNT_W-1:0]      rd_count
);

  localparam int NT   = NTX * NTY;
  localparam int TX_W = (NTX > 1) ? $clog2(NTX) : 1;
  localparam int TY_W = (NTY > 1) ? $clog2(NTY) : 1;
  localparam int NTW1 = NT_W + 1;
  localparam logic [NT_W-1:0] LAST_TILE = NT_W'(NT - 1);
  localparam logic [NTW1-1:0] NT_LIMIT  = NTW1'(NT);

  state_e                 state_q, state_d;
  logic [NT_W-1:0]        clrIdx_q, clrIdx_d;
  logic [TX_W-1:0]        curTx_q, curTx_d, walkTx0_q, walkTx0_d, walkTx1_q, walkTx1_d;
  logic [TY_W-1:0]        curTy_q, curTy_d, walkTy1_q, walkTy1_d;
  logic [LID_W-1:0]       walkId_q, walkId_d;
  logic                   drop_q, drop_d;
  logic                   rdResp_q, rdResp_d;
  logic [MAX_LIGHTS-1:0]  rdMask_q, rdMask_d;
  logic [CNT_W-1:0]       rdCount_q, rdCount_d;

  logic [MAX_LIGHTS-1:0]  masks_q [NT];
  logic                   maskWe, maskClr;
  logic [NT_W-1:0]        maskIdx;
  logic [MAX_LIGHTS-1:0]  selMask;
  logic                   rdTileOk;

  logic [TX_W-1:0]        boxTx0, boxTx1;
  logic [TY_W-1:0]        boxTy0, boxTy1;
  logic                   boxDrop;

  tile_bbox_clamp #(
    .COORD_W   (COORD_W),
    .TILE_W    (TILE_W),
    .TILE_H    (TILE_H),
    .NTX       (NTX),
    .NTY       (NTY),
    .MAX_LIGHTS(MAX_LIGHTS),
    .LID_W     (LID_W),
    .TX_W      (TX_W),
    .TY_W      (TY_W)
  ) u_clamp (
    .x0_i  (in_x0),
    .y0_i  (in_y0),
    .x1_i  (in_x1),
    .y1_i  (in_y1),
    .id_i  (in_light_id),
    .tx0_o (boxTx0),
    .tx1_o (boxTx1),
    .ty0_o (boxTy0),
    .ty1_o (boxTy1),
    .drop_o(boxDrop)
  );

  assign rdTileOk = {1'b0, rd_tile} < NT_LIMIT;
  assign selMask  = rdTileOk ? masks_q[rd_tile] : '0;

  always_comb begin
    state_d   = state_q;
    clrIdx_d  = clrIdx_q;
    curTx_d   = curTx_q;
    curTy_d   = curTy_q;
    walkTx0_d = walkTx0_q;
    walkTx1_d = walkTx1_q;
    walkTy1_d = walkTy1_q;
    walkId_d  = walkId_q;
    drop_d    = 1'b0;
    rdResp_d  = 1'b0;
    rdMask_d  = '0;
    rdCount_d = '0;
    in_ready  = 1'b0;
    rd_ready  = 1'b0;
    maskWe    = 1'b0;
    maskClr   = 1'b0;
    maskIdx   = clrIdx_q;
    case (state_q)
      ST_CLEAR: begin
        maskWe  = 1'b1;
        maskClr = 1'b1;
        if (clrIdx_q == LAST_TILE) begin
          state_d  = ST_IDLE;
          clrIdx_d = '0;
        end else begin
          clrIdx_d = clrIdx_q + NT_W'(1);
        end
      end
      ST_IDLE: begin
        // Readback yields to a pending light so a read never overlaps a walk write.
        in_ready = !clear_req;
        rd_ready = !clear_req && !in_valid;
        if (clear_req) begin
          state_d  = ST_CLEAR;
          clrIdx_d = '0;
        end else if (in_valid) begin
          if (boxDrop) begin
            drop_d = 1'b1;
          end else begin
            state_d   = ST_WALK;
            curTx_d   = boxTx0;
            curTy_d   = boxTy0;
            walkTx0_d = boxTx0;
            walkTx1_d = boxTx1;
            walkTy1_d = boxTy1;
            walkId_d  = in_light_id;
          end
        end else if (rd_valid) begin
          rdResp_d  = 1'b1;
          rdMask_d  = selMask;
          rdCount_d = CNT_W'(popcount(POPCNT_MAX_W'(selMask)));
        end
      end
      ST_WALK: begin
        maskWe  = 1'b1;
        maskIdx = NT_W'(tile_index(32'(curTx_q), 32'(curTy_q), NTX));
        if (curTx_q == walkTx1_q) begin
          curTx_d = walkTx0_q;
          if (curTy_q == walkTy1_q) begin
            state_d = ST_IDLE;
          end else begin
            curTy_d = curTy_q + TY_W'(1);
          end
        end else begin
          curTx_d = curTx_q + TX_W'(1);
        end
      end
      default: begin
        state_d  = ST_CLEAR;
        clrIdx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clrIdx_q  <= '0;
      curTx_q   <= '0;
      curTy_q   <= '0;
      walkTx0_q <= '0;
      walkTx1_q <= '0;
      walkTy1_q <= '0;
      walkId_q  <= '0;
      drop_q    <= 1'b0;
      rdResp_q  <= 1'b0;
      rdMask_q  <= '0;
      rdCount_q <= '0;
    end else begin
      state_q   <= state_d;
      clrIdx_q  <= clrIdx_d;
      curTx_q   <= curTx_d;
      curTy_q   <= curTy_d;
      walkTx0_q <= walkTx0_d;
      walkTx1_q <= walkTx1_d;
      walkTy1_q <= walkTy1_d;
      walkId_q  <= walkId_d;
      drop_q    <= drop_d;
      rdResp_q  <= rdResp_d;
      rdMask_q  <= rdMask_d;
      rdCount_q <= rdCount_d;
    end
  end

  // Mask storage has no reset; the clear sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (maskWe) begin
      if (maskClr) begin
        masks_q[maskIdx] <= '0;
      end else begin
        masks_q[maskIdx][walkId_q] <= 1'b1;
      end
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign clear_done    = (state_q == ST_CLEAR) && (clrIdx_q == LAST_TILE);
  assign drop          = drop_q;
  assign rd_resp_valid = rdResp_q;
  assign rd_mask       = rdMask_q;
  assign rd_count      = rdCount_q;

endmodule

// File: tb/tb_tile_light_binner_seq.sv
// Self-checking bench for tile_light_binner_seq on a 64x48 screen with 16x16 tiles:
// a busy-countdown model checked every cycle, plus literal expectations per scenario.
module tb_tile_light_binner_seq;

  localparam int NTX = 4;
  localparam int NTY = 3;
  localparam int NT  = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_light_id = '0;
  logic [15:0] in_x0 = '0, in_y0 = '0, in_x1 = '0, in_y1 = '0;
  logic        clear_req = 1'b0;
  logic        clear_done, busy, drop;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [3:0]  rd_tile = '0;
  logic        rd_resp_valid;
  logic [63:0] rd_mask;
  logic [6:0]  rd_count;

  int errors = 0;
  int checks = 0;

  int          mBusyLeft = NT;
  bit          mIsClear = 1'b1;
  bit          mDrop = 1'b0;
  bit          mResp = 1'b0;
  logic [63:0] mRespMask = '0;
  logic [63:0] mMask [NT];
  int          mx0, my0, mx1, my1, mid, mtx0, mtx1, mty0, mty1;
  bit          expBusy;

  always #5 clk = ~clk;

  tile_light_binner_seq #(
    .SCREEN_W  (64),
    .SCREEN_H  (48),
    .TILE_W    (16),
    .TILE_H    (16),
    .MAX_LIGHTS(64),
    .COORD_W   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_light_id  (in_light_id),
    .in_x0        (in_x0),
    .in_y0        (in_y0),
    .in_x1        (in_x1),
    .in_y1        (in_y1),
    .clear_req    (clear_req),
    .clear_done   (clear_done),
    .busy         (busy),
    .drop         (drop),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_tile      (rd_tile),
    .rd_resp_valid(rd_resp_valid),
    .rd_mask      (rd_mask),
    .rd_count     (rd_count)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a busy countdown plus atomic mask effects at acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusyLeft = NT;
      mIsClear  = 1'b1;
      mDrop     = 1'b0;
      mResp     = 1'b0;
      for (int t = 0; t < NT; t++) mMask[t] = '0;
    end else begin
      mDrop = 1'b0;
      mResp = 1'b0;
      if (mBusyLeft > 0) begin
        mBusyLeft--;
      end else if (clear_req) begin
        mBusyLeft = NT;
        mIsClear  = 1'b1;
        for (int t = 0; t < NT; t++) mMask[t] = '0;
      end else if (in_valid) begin
        mx0 = int'(in_x0); my0 = int'(in_y0); mx1 = int'(in_x1); my1 = int'(in_y1);
        mid = int'(in_light_id);
        mtx0 = mx0 / 16; mty0 = my0 / 16;
        mtx1 = (mx1 / 16 > NTX - 1) ? NTX - 1 : mx1 / 16;
        mty1 = (my1 / 16 > NTY - 1) ? NTY - 1 : my1 / 16;
        if (mx0 > mx1 || my0 > my1 || mtx0 >= NTX || mty0 >= NTY || mid >= 64) begin
          mDrop = 1'b1;
        end else begin
          mBusyLeft = (mtx1 - mtx0 + 1) * (mty1 - mty0 + 1);
          mIsClear  = 1'b0;
          for (int ty = mty0; ty <= mty1; ty++)
            for (int tx = mtx0; tx <= mtx1; tx++)
              mMask[ty * NTX + tx][mid] = 1'b1;
        end
      end else if (rd_valid) begin
        mResp     = 1'b1;
        mRespMask = (int'(rd_tile) < NT) ? mMask[rd_tile] : 64'd0;
      end
    end
  end

  always @(negedge clk) begin
    expBusy = (mBusyLeft > 0);
    checkOutput("busy", 64'(busy), 64'(expBusy));
    checkOutput("in_ready", 64'(in_ready), 64'(!expBusy && !clear_req));
    checkOutput("rd_ready", 64'(rd_ready), 64'(!expBusy && !clear_req && !in_valid));
    checkOutput("clear_done", 64'(clear_done), 64'(mIsClear && mBusyLeft == 1));
    checkOutput("drop", 64'(drop), 64'(mDrop));
    checkOutput("rd_resp_valid", 64'(rd_resp_valid), 64'(mResp));
    if (mResp) begin
      checkOutput("rd_mask", rd_mask, mRespMask);
      checkOutput("rd_count", 64'(rd_count), 64'($countones(mRespMask)));
    end
  end

  task automatic waitIdle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitIdle: busy still 1 after %0d cycles, required 0", budget);
    end
  endtask

  task automatic countBusy(output int n);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic sweepTiming(output int doneCycle, output int idleCycle);
    doneCycle = 0;
    idleCycle = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (clear_done && doneCycle == 0) doneCycle = c;
      if (!busy && idleCycle == 0) idleCycle = c;
    end
  endtask

  task automatic applyStimulus(input logic [5:0] id, input logic [15:0] x0, input logic [15:0] y0,
                               input logic [15:0] x1, input logic [15:0] y1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_light_id = id;
    in_x0 = x0; in_y0 = y0; in_x1 = x1; in_y1 = y1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic doRead(input int tile, output logic [63:0] m, output logic [6:0] n);
    @(posedge clk); #1;
    rd_valid = 1'b1;
    rd_tile  = 4'(tile);
    @(posedge clk); #1;
    rd_valid = 1'b0;
    m = rd_mask;
    n = rd_count;
  endtask

  task automatic pulseClear();
    @(posedge clk); #1;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
  endtask

  logic [63:0] m;
  logic [6:0]  n;
  int          cnt, doneC, idleC, acceptC;
  int          rx0, ry0, rx1, ry1, sel;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    sweepTiming(doneC, idleC);
    checkOutput("reset clear_done cycle", 64'(doneC), 64'd12);
    checkOutput("reset first idle cycle", 64'(idleC), 64'd13);
    for (int t = 0; t < NT; t++) begin
      doRead(t, m, n);
      checkOutput("reset tile mask", m, 64'd0);
    end

    applyStimulus(6'd5, 16'd10, 16'd10, 16'd20, 16'd20);
    countBusy(cnt);
    checkOutput("id5 walk cycles", 64'(cnt), 64'd4);
    doRead(5, m, n);
    checkOutput("tile5 mask", m, 64'h20);
    checkOutput("tile5 count", 64'(n), 64'd1);
    doRead(2, m, n);
    checkOutput("tile2 mask", m, 64'd0);

    applyStimulus(6'd63, 16'd0, 16'd40, 16'd1000, 16'd47);
    countBusy(cnt);
    checkOutput("id63 walk cycles", 64'(cnt), 64'd4);
    doRead(11, m, n);
    checkOutput("tile11 mask id63", m, 64'h8000_0000_0000_0000);
    applyStimulus(6'd5, 16'd0, 16'd40, 16'd1000, 16'd47);
    countBusy(cnt);
    doRead(11, m, n);
    checkOutput("tile11 mask two lights", m, 64'h8000_0000_0000_0020);
    checkOutput("tile11 count", 64'(n), 64'd2);

    applyStimulus(6'd9, 16'd100, 16'd0, 16'd110, 16'd10);
    checkOutput("drop offgrid pulse", 64'(drop), 64'd1);
    checkOutput("in_ready after offgrid drop", 64'(in_ready), 64'd1);
    applyStimulus(6'd9, 16'd30, 16'd0, 16'd20, 16'd10);
    checkOutput("drop inverted pulse", 64'(drop), 64'd1);
    doRead(0, m, n);
    checkOutput("tile0 after drops", m, 64'h20);

    @(posedge clk); #1;
    clear_req = 1'b1; in_valid = 1'b1; in_light_id = 6'd7;
    in_x0 = 16'd0; in_y0 = 16'd0; in_x1 = 16'd0; in_y1 = 16'd0;
    @(posedge clk); #1;
    clear_req = 1'b0;
    doneC = 0; acceptC = 0;
    for (int c = 1; c <= 40 && acceptC == 0; c++) begin
      @(negedge clk);
      if (clear_done) doneC = c;
      if (in_ready) acceptC = c;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("clear+light clear_done cycle", 64'(doneC), 64'd12);
    checkOutput("clear+light accept cycle", 64'(acceptC), 64'd13);
    waitIdle(20);
    doRead(0, m, n);
    checkOutput("tile0 after clear", m, 64'h80);
    doRead(11, m, n);
    checkOutput("tile11 after clear", m, 64'd0);

    applyStimulus(6'd9, 16'd0, 16'd0, 16'd31, 16'd31);
    @(posedge clk); #1;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset mid-walk busy", 64'(busy), 64'd1);
    checkOutput("reset mid-walk in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset mid-walk rd_ready", 64'(rd_ready), 64'd0);
    checkOutput("reset mid-walk drop", 64'(drop), 64'd0);
    checkOutput("reset mid-walk clear_done", 64'(clear_done), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sweepTiming(doneC, idleC);
    checkOutput("re-reset clear_done cycle", 64'(doneC), 64'd12);
    checkOutput("re-reset first idle cycle", 64'(idleC), 64'd13);
    foreach (m[i]) begin end
    for (int k = 0; k < 4; k++) begin
      doRead((k / 2) * NTX + (k % 2), m, n);
      checkOutput("walked tile after reset", m, 64'd0);
    end

    for (int it = 0; it < 60; it++) begin
      waitIdle(100);
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        rx0 = $urandom_range(0, 90);
        ry0 = $urandom_range(0, 60);
        rx1 = ($urandom_range(0, 7) == 0 && rx0 > 0) ? rx0 - 1 : rx0 + $urandom_range(0, 40);
        ry1 = ($urandom_range(0, 7) == 0 && ry0 > 0) ? ry0 - 1 : ry0 + $urandom_range(0, 30);
        applyStimulus(6'($urandom_range(0, 63)), 16'(rx0), 16'(ry0), 16'(rx1), 16'(ry1));
      end else if (sel < 9) begin
        doRead($urandom_range(0, 15), m, n);
      end else begin
        pulseClear();
      end
    end
    waitIdle(100);
    for (int t = 0; t < 16; t++) doRead(t, m, n);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
